// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings for the counter_updown_mod family.
//   MODE_WRAP / MODE_SAT : values of the mode input (wrap or saturate at a boundary)
//   DIR_UP / DIR_DOWN    : values of the dir input
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/counter_updown_mod_if.sv
// counter_updown_mod_if: control and status bundle of counter_updown_mod.
//   en, dir, mode, load, load_val, mod_max : controls, driven by the master
//   count, carry, borrow                   : registered outputs of the counter
//   at_max, at_zero                        : combinational status of the counter
// There is no handshake. Controls are sampled on every rising clock edge, and
// outputs are valid in every cycle.
interface counter_updown_mod_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_max;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             borrow;
    logic             at_max;
    logic             at_zero;

    modport master (
        output en, dir, mode, load, load_val, mod_max,
        input  count, carry, borrow, at_max, at_zero
    );

    modport slave (
        input  en, dir, mode, load, load_val, mod_max,
        output count, carry, borrow, at_max, at_zero
    );
endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles by PRESCALE.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, phase -> 0
//   clr   : synchronous phase clear, phase -> 0
//   en    : advance the phase this cycle
//   tick  : combinational, high on the enabled cycle that completes a period
// The phase runs 0..PRESCALE-1. When en is low, the phase holds.
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign tick = en && (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (tick) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: up/down counter with a programmable modulus.
//   The count range is 0..mod_max. The counter wraps or saturates at either
//   boundary, and it has a count enable and a parallel load. carry and borrow
//   are registered one-cycle event pulses.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : counter_updown_mod_if.slave
//           (en, dir, mode, load, load_val, mod_max -> count, carry, borrow, at_max, at_zero)
// Parameters: WIDTH (>=2) is the counter width. PRESCALE (>=1) is the number of
// enabled cycles per step.
// Optional feature macro PRESCALE_EN: when it is defined, a step happens only on
// every PRESCALE-th enabled cycle. When it is undefined, every enabled cycle is
// a step and PRESCALE is not used.
// Priority on each edge: reset > load > step > hold.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_updown_mod_if.slave  bus
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             carry_q;
    logic             carry_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             step;

`ifdef PRESCALE_EN
    // A load restarts the prescale period. Cycles that carry a load do not
    // advance the phase, because the load takes priority over the step.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.load),
        .en    (bus.en && !bus.load),
        .tick  (step)
    );
`else
    assign step = bus.en && !bus.load;
`endif

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;
        end else if (step) begin
            if (bus.dir == DIR_UP) begin
                if (count_q < bus.mod_max) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    // At or above the top boundary. The >= also catches a
                    // mod_max that was lowered under the current count.
                    carry_d = 1'b1;
                    count_d = (bus.mode == MODE_WRAP) ? '0 : bus.mod_max;
                end
            end else begin
                if (count_q == '0) begin
                    borrow_d = 1'b1;
                    count_d  = (bus.mode == MODE_WRAP) ? bus.mod_max : '0;
                end else if (count_q > bus.mod_max) begin
                    // mod_max was lowered at runtime. Pull the count back into range.
                    count_d = bus.mod_max;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.carry   = carry_q;
    assign bus.borrow  = borrow_q;
    assign bus.at_max  = (count_q >= bus.mod_max);
    assign bus.at_zero = (count_q == '0);
endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised synchronous up/down counter, successor to the fixed 8-bit up/down counter. Adds a programmable modulus (count range 0..mod_max), wrap or saturate mode, count enable, parallel load, and registered carry/borrow event pulses. Used as a general timing and event counter in datapath and control blocks, and is cascadable through carry/borrow.

Parameters:
WIDTH, 8, counter width in bits (>=2)
PRESCALE, 4, steps per count when PRESCALE_EN is defined (>=1); ignored otherwise

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable
dir  input  1  1 = up, 0 = down
mode  input  1  0 = wrap, 1 = saturate
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
mod_max  input  WIDTH  upper bound of count range (inclusive)
count  output  WIDTH  current count, registered
carry  output  1  registered one-cycle pulse: up step at top boundary
borrow  output  1  registered one-cycle pulse: down step at bottom boundary
at_max  output  1  combinational: count >= mod_max
at_zero  output  1  combinational: count == 0

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state updates on rising clk.
- Reset values: count = 0, carry = 0, borrow = 0, so at_zero = 1. at_max = (mod_max == 0).
- Priority on each edge: reset > load > step > hold.
- Load: count <= min(load_val, mod_max). carry and borrow = 0. Load overrides en.
- Step occurs when en = 1 and load = 0 (without PRESCALE_EN). Result is visible on count the next cycle, so latency is 1.
- Up step, count < mod_max: count + 1.
- Up step, count >= mod_max, wrap mode: count <= 0, carry = 1.
- Up step, count >= mod_max, saturate mode: count <= mod_max, carry = 1. carry pulses on every attempted step at max.
- Down step, count > 0: count - 1. If count > mod_max (mod_max lowered at runtime): count <= mod_max instead.
- Down step, count == 0, wrap mode: count <= mod_max, borrow = 1.
- Down step, count == 0, saturate mode: count <= 0, borrow = 1.
- carry and borrow are 0 in every cycle not produced by a boundary step. They are never both 1.
- mod_max == 0: count stays 0. Each enabled up step pulses carry; each enabled down step pulses borrow.
- mod_max, dir and mode may change on any cycle. They are sampled only at the edge where they are used. No internal state other than count and the event flags (plus the prescaler when enabled).
- en = 0: count holds and carry/borrow = 0.
- Arithmetic is unsigned, WIDTH bits. mod_max = 2^WIDTH-1 gives natural binary wrap.

Optional Feature:
PRESCALE_EN
- Defined: an internal prescaler counts enabled cycles 0..PRESCALE-1. A step occurs only on the enabled cycle where the prescaler equals PRESCALE-1, and the prescaler then returns to 0.
- en = 0 holds the prescaler. reset and load clear it to 0.
- carry and borrow pulse only on actual steps.
- Not defined: no prescaler logic; every enabled cycle is a step.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants MODE_WRAP = 1'b0, MODE_SAT = 1'b1
  - direction constants DIR_UP = 1'b1, DIR_DOWN = 1'b0
- Natural sub-module: counter_prescaler (parameter PRESCALE; ports clk, reset, clr, en, tick), instantiated only under PRESCALE_EN.
- Next-count logic stays in the top module.

Test Plan:
- Reset, then WIDTH=8, mod_max=9, wrap, dir=1, en=1 for 11 cycles -> count 0,1,..,9,0; carry=1 exactly in the cycle count shows 0; at_max=1 while count=9.
- mod_max=9, wrap, count=0, dir=0, one step -> count=9, borrow=1 for one cycle; next step -> 8, borrow=0.
- mode=1, mod_max=200, load 198, then up 4 steps -> count 199,200,200,200; carry=1 on the 3rd and 4th cycles only. Then dir=0 from count=1 for 3 steps -> 0,0,0 with borrow on the 2nd and 3rd.
- load_val=250, mod_max=100, load=1 and en=1 same cycle -> count=100, no carry. Then set mod_max=50 and step down -> count=50.
- Counting at count=5 with reset=1 and load=1 (load_val=7) same cycle -> count=0, carry=borrow=0; en=0 for 3 cycles -> count holds 0.
- With PRESCALE_EN, PRESCALE=3, en=1 continuous, up -> count increments every 3rd cycle; drop en for 2 cycles mid-period -> phase preserved; load clears phase.
